// File: rtl/dct_coeff_serializer_if.sv
// Frame-in / beat-out bundle for dct_coeff_serializer.
// The slave modport is the serializer; the master modport is the surrounding logic.
interface dct_coeff_serializer_if #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned N_COEF = 8,
  parameter int unsigned THR_W  = 12,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned IDX_W = $clog2(N_COEF);

  logic                       coef_valid;
  logic                       coef_ready;
  logic [N_COEF*COEF_W-1:0]   coef_bus;
  logic [THR_W-1:0]           threshold;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [COEF_W-1:0]   out_data;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_last;
  logic [CNT_W-1:0]           frame_cnt;

  modport master (
    output coef_valid, coef_bus, threshold, out_ready,
    input  coef_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );

  modport slave (
    input  coef_valid, coef_bus, threshold, out_ready,
    output coef_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );
endinterface

// File: rtl/dct_coeff_serializer.sv
// Captures a frame of DCT coefficients, zeroes those below threshold, streams them out one per beat.
// Optional ZERO_SKIP_EN: skip zero beats except the last index, which always carries out_last.
module dct_coeff_serializer #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned N_COEF = 8,
  parameter int unsigned THR_W  = 12,
  parameter int unsigned CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  dct_coeff_serializer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_COEF);
  localparam int unsigned MAG_W = COEF_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_next;
  logic signed [COEF_W-1:0] bank     [N_COEF];
  logic signed [COEF_W-1:0] thr_coef [N_COEF];
  logic [IDX_W-1:0]         idx, idx_first, idx_next;
  logic [CNT_W-1:0]         cnt;
  logic                     ready, capture, xfer, last_xfer;

  // Magnitude is one bit wider so that the most negative code has a representable |c|.
  function automatic logic signed [COEF_W-1:0] apply_thr(
    input logic signed [COEF_W-1:0] c,
    input logic [THR_W-1:0]         t
  );
    logic [MAG_W-1:0] ext, mag;
    ext = {c[COEF_W-1], c};
    mag = c[COEF_W-1] ? (~ext + 1'b1) : ext;
    return (mag < MAG_W'(t)) ? '0 : c;
  endfunction

`ifdef ZERO_SKIP_EN
  logic [N_COEF-1:0] new_nz, bank_nz;

  // First nonzero position at or after start; the last index is the fallback.
  function automatic logic [IDX_W-1:0] next_emit(
    input logic [N_COEF-1:0] nz,
    input int unsigned       start
  );
    logic [IDX_W-1:0] r;
    logic             found;
    r     = LAST_IDX;
    found = 1'b0;
    for (int unsigned i = 0; i < N_COEF - 1; i++) begin
      if (!found && i >= start && nz[i]) begin
        r     = IDX_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_COEF; i++) begin
      thr_coef[i] = apply_thr(bus.coef_bus[i*COEF_W +: COEF_W], bus.threshold);
    end
  end

`ifdef ZERO_SKIP_EN
  always_comb begin
    new_nz  = '0;
    bank_nz = '0;
    for (int unsigned i = 0; i < N_COEF; i++) begin
      new_nz[i]  = |thr_coef[i];
      bank_nz[i] = |bank[i];
    end
    idx_first = next_emit(new_nz, 0);
    idx_next  = next_emit(bank_nz, 32'(idx) + 1);
  end
`else
  always_comb begin
    idx_first = '0;
    idx_next  = idx + 1'b1;
  end
`endif

  // Ready is combinational on out_ready so a new frame can load on the last beat without a bubble.
  always_comb begin
    xfer       = (state == SEND) && bus.out_ready;
    last_xfer  = xfer && (idx == LAST_IDX);
    ready      = !rst && ((state == IDLE) || last_xfer);
    capture    = ready && bus.coef_valid;
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = SEND;
      SEND:    if (last_xfer && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < N_COEF; i++) bank[i] <= '0;
    end else begin
      if (last_xfer) cnt <= cnt + 1'b1;
      if (capture) begin
        bank <= thr_coef;
        idx  <= idx_first;
      end else if (last_xfer) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx_next;
      end
    end
  end

  assign bus.coef_ready = ready;
  assign bus.out_valid  = (state == SEND);
  assign bus.out_data   = bank[idx];
  assign bus.out_idx    = idx;
  assign bus.out_last   = (state == SEND) && (idx == LAST_IDX);
  assign bus.frame_cnt  = cnt;
endmodule

// File: tb/tb_dct_coeff_serializer.sv
// Directed bench for dct_coeff_serializer; ZERO_SKIP_EN selects the zero-skip scenario set.
module tb_dct_coeff_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_coeff_serializer_if bus ();

  dct_coeff_serializer #(
    .COEF_W(13),
    .N_COEF(8),
    .THR_W (12),
    .CNT_W (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef logic signed [12:0] frame_t [8];

  int     tests = 0;
  int     fails = 0;
  int     exp_cnt = 0;
  frame_t f_a, exp_a, f_b, exp_b, f_zero;

  function automatic logic [103:0] pack(input frame_t f);
    logic [103:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*13 +: 13] = f[i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input frame_t f, input logic [11:0] thr);
    bus.coef_bus   = pack(f);
    bus.threshold  = thr;
    bus.coef_valid = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    bus.coef_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.coef_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.coef_bus   = '0;
    bus.threshold  = '0;
    tick();
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 13'sd0) begin fails++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    tests++; if (bus.frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    tests++; if (bus.coef_ready !== 1'b0) begin fails++; $display("FAIL reset_coef_ready: got %0d want 0", bus.coef_ready); end
    tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %0d want 0", bus.out_last); end
    rst = 1'b0;
    #1;
    tests++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL idle_coef_ready: got %0d want 1", bus.coef_ready); end
  endtask

`ifndef ZERO_SKIP_EN
  task automatic test_single_frame;
    bus.coef_bus   = pack(f_a);
    bus.threshold  = 12'd5;
    bus.out_ready  = 1'b1;
    bus.coef_valid = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL pre_capture_valid: got %0d want 0", bus.out_valid); end
    tick();
    bus.coef_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid[%0d]: got %0d want 1", k, bus.out_valid); end
      tests++; if (bus.out_data !== exp_a[k]) begin fails++; $display("FAIL single_data[%0d]: got %0d want %0d", k, bus.out_data, exp_a[k]); end
      tests++; if (bus.out_idx !== 3'(k)) begin fails++; $display("FAIL single_idx[%0d]: got %0d want %0d", k, bus.out_idx, k); end
      tests++; if (bus.out_last !== (k == 7)) begin fails++; $display("FAIL single_last[%0d]: got %0d want %0d", k, bus.out_last, k == 7); end
      tick();
    end
    exp_cnt++;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_idle_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL single_frame_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
  endtask

  task automatic test_stall;
    int n = 0;
    int stalls = 0;
    load_frame(f_a, 12'd5);
    for (int c = 0; c < 30 && n < 8; c++) begin
      if (bus.out_valid && bus.out_idx == 3'd3 && stalls < 4) begin
        bus.out_ready = 1'b0;
        #1;
        stalls++;
        tests++; if (bus.out_data !== -13'sd50) begin fails++; $display("FAIL stall_data: got %0d want -50", bus.out_data); end
        tests++; if (bus.out_idx !== 3'd3) begin fails++; $display("FAIL stall_idx: got %0d want 3", bus.out_idx); end
        tests++; if (bus.coef_ready !== 1'b0) begin fails++; $display("FAIL stall_coef_ready: got %0d want 0", bus.coef_ready); end
      end else begin
        bus.out_ready = 1'b1;
        #1;
        if (bus.out_valid) begin
          tests++; if (bus.out_data !== exp_a[n]) begin fails++; $display("FAIL stall_beat_data[%0d]: got %0d want %0d", n, bus.out_data, exp_a[n]); end
          tests++; if (bus.out_idx !== 3'(n)) begin fails++; $display("FAIL stall_beat_idx[%0d]: got %0d want %0d", n, bus.out_idx, n); end
          n++;
        end
      end
      tick();
    end
    bus.out_ready = 1'b1;
    exp_cnt++;
    tests++; if (n !== 8) begin fails++; $display("FAIL stall_beat_count: got %0d want 8", n); end
    tests++; if (stalls !== 4) begin fails++; $display("FAIL stall_cycles: got %0d want 4", stalls); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stall_idle_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL stall_frame_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back;
    logic signed [12:0] want;
    bus.coef_bus   = pack(f_a);
    bus.threshold  = 12'd5;
    bus.out_ready  = 1'b1;
    bus.coef_valid = 1'b1;
    tick();
    // Second frame waits on the bus; threshold change must not affect the frame in flight.
    bus.coef_bus  = pack(f_b);
    bus.threshold = 12'd21;
    for (int k = 0; k < 16; k++) begin
      want = (k < 8) ? exp_a[k] : exp_b[k-8];
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %0d want 1", k, bus.out_valid); end
      tests++; if (bus.out_data !== want) begin fails++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, bus.out_data, want); end
      tests++; if (bus.out_idx !== 3'(k % 8)) begin fails++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", k, bus.out_idx, k % 8); end
      if (k == 3) begin
        tests++; if (bus.coef_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_mid: got %0d want 0", bus.coef_ready); end
      end
      if (k == 7) begin
        tests++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_last: got %0d want 1", bus.coef_ready); end
      end
      tick();
      if (k == 7) bus.coef_valid = 1'b0;
    end
    exp_cnt += 2;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL b2b_frame_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    load_frame(f_a, 12'd5);
    for (int k = 0; k < 4; k++) tick();
    tests++; if (bus.out_idx !== 3'd4) begin fails++; $display("FAIL mid_pre_idx: got %0d want 4", bus.out_idx); end
    rst = 1'b1;
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.frame_cnt !== 16'd0) begin fails++; $display("FAIL mid_reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    load_frame(f_a, 12'd5);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL restart_valid: got %0d want 1", bus.out_valid); end
    tests++; if (bus.out_idx !== 3'd0) begin fails++; $display("FAIL restart_idx: got %0d want 0", bus.out_idx); end
    tests++; if (bus.out_data !== 13'sd100) begin fails++; $display("FAIL restart_data: got %0d want 100", bus.out_data); end
    for (int k = 0; k < 8; k++) tick();
    exp_cnt++;
    tests++; if (bus.frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL restart_frame_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
  endtask
`else
  task automatic test_zero_skip;
    logic [2:0]         sk_idx  [5];
    logic signed [12:0] sk_data [5];
    sk_idx  = '{3'd0, 3'd2, 3'd3, 3'd6, 3'd7};
    sk_data = '{13'sd100, 13'sd7, -13'sd50, 13'h1000, 13'sd4095};
    load_frame(f_zero, 12'd0);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid: got %0d want 1", bus.out_valid); end
    tests++; if (bus.out_idx !== 3'd7) begin fails++; $display("FAIL zero_idx: got %0d want 7", bus.out_idx); end
    tests++; if (bus.out_data !== 13'sd0) begin fails++; $display("FAIL zero_data: got %0d want 0", bus.out_data); end
    tests++; if (bus.out_last !== 1'b1) begin fails++; $display("FAIL zero_last: got %0d want 1", bus.out_last); end
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL zero_idle_valid: got %0d want 0", bus.out_valid); end
    load_frame(f_a, 12'd5);
    for (int k = 0; k < 5; k++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL skip_valid[%0d]: got %0d want 1", k, bus.out_valid); end
      tests++; if (bus.out_idx !== sk_idx[k]) begin fails++; $display("FAIL skip_idx[%0d]: got %0d want %0d", k, bus.out_idx, sk_idx[k]); end
      tests++; if (bus.out_data !== sk_data[k]) begin fails++; $display("FAIL skip_data[%0d]: got %0d want %0d", k, bus.out_data, sk_data[k]); end
      tests++; if (bus.out_last !== (k == 4)) begin fails++; $display("FAIL skip_last[%0d]: got %0d want %0d", k, bus.out_last, k == 4); end
      tick();
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL skip_idle_valid: got %0d want 0", bus.out_valid); end
    tests++; if (bus.frame_cnt !== 16'd2) begin fails++; $display("FAIL skip_frame_cnt: got %0d want 2", bus.frame_cnt); end
  endtask
`endif

  initial begin
    f_a    = '{13'sd100, -13'sd3, 13'sd7, -13'sd50, 13'sd0, 13'sd2, 13'h1000, 13'sd4095};
    exp_a  = '{13'sd100, 13'sd0, 13'sd7, -13'sd50, 13'sd0, 13'sd0, 13'h1000, 13'sd4095};
    f_b    = '{-13'sd1, 13'sd20, -13'sd20, 13'sd300, -13'sd300, 13'sd6, -13'sd6, 13'sd21};
    exp_b  = '{13'sd0, 13'sd0, 13'sd0, 13'sd300, -13'sd300, 13'sd0, 13'sd0, 13'sd21};
    f_zero = '{13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0};
    test_reset();
`ifndef ZERO_SKIP_EN
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
`else
    test_zero_skip();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
